// File: rtl/missile_pool_ctrl_if.sv
// Fire-scheduling bundle between the fire sources, the missile pool controller and the mover array.
// The pool controller sits on the slave side; fire sources / bench drive the master side.
interface missile_pool_ctrl_if #(
    parameter int NUM_TANKS = 4,
    parameter int NUM_SLOTS = 4,
    parameter int TW        = $clog2(NUM_TANKS),
    parameter int SW        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
);
    logic                      startOfFrame;
    logic [NUM_TANKS-1:0]      fireReq;
    logic [NUM_TANKS-1:0]      tankAlive;
    logic [NUM_SLOTS-1:0]      slotDone;
    logic [NUM_SLOTS-1:0]      slotFire;
    logic [NUM_SLOTS-1:0]      slotBusy;
    logic [NUM_SLOTS*TW-1:0]   slotOwner;
    logic [NUM_TANKS-1:0]      tankInFlight;
    logic                      grantValid;
    logic [TW-1:0]             grantTank;
    logic [SW-1:0]             grantSlot;

    modport master (
        output startOfFrame, fireReq, tankAlive, slotDone,
        input  slotFire, slotBusy, slotOwner, tankInFlight, grantValid, grantTank, grantSlot
    );

    modport slave (
        input  startOfFrame, fireReq, tankAlive, slotDone,
        output slotFire, slotBusy, slotOwner, tankInFlight, grantValid, grantTank, grantSlot
    );
endinterface

// File: rtl/missile_pool_ctrl.sv
// Per-frame round-robin arbiter that hands free missile movers to requesting tanks,
// tracking slot ownership, one-missile-per-tank limits and per-tank fire cooldown.
module missile_pool_ctrl #(
    parameter int NUM_TANKS       = 4,
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int TW              = $clog2(NUM_TANKS),
    parameter int SW              = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                clk,
    input  logic                resetN,
    missile_pool_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ARB, ISSUE} state_t;

    state_t               state;
    logic [TW-1:0]        rr_ptr;
    logic [TW-1:0]        grant_tank;
    logic [SW-1:0]        grant_slot;
    logic                 grant_valid;
    logic [NUM_SLOTS-1:0] slot_fire;
    logic [NUM_SLOTS-1:0] slot_busy;
    logic [TW-1:0]        slot_owner [NUM_SLOTS];
    logic [NUM_TANKS-1:0] in_flight;
    logic [5:0]           cooldown   [NUM_TANKS];

    logic [NUM_TANKS-1:0] eligible;
    logic                 win_found;
    logic [TW-1:0]        win_tank;
    logic                 slot_found;
    logic [SW-1:0]        free_slot;
    logic [NUM_SLOTS*TW-1:0] owner_packed;

    // NOTE: combinational blocks use blocking assignments and give every output a
    // default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        for (int i = 0; i < NUM_TANKS; i++) begin
            eligible[i] = bus.fireReq[i] & bus.tankAlive[i] & ~in_flight[i]
                          & (cooldown[i] == 6'd0);
        end
    end

    // Scanning from the far end lets the last hit (smallest offset / lowest slot) win.
    always_comb begin
        win_found  = 1'b0;
        win_tank   = '0;
        slot_found = 1'b0;
        free_slot  = '0;
        for (int k = NUM_TANKS - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_TANKS;
            if (eligible[TW'(idx)]) begin
                win_found = 1'b1;
                win_tank  = TW'(idx);
            end
        end
        for (int j = NUM_SLOTS - 1; j >= 0; j--) begin
            if (!slot_busy[j]) begin
                slot_found = 1'b1;
                free_slot  = SW'(j);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the small owner and
    // cooldown arrays are flops, so they are reset along with everything else.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_tank  <= '0;
            grant_slot  <= '0;
            grant_valid <= 1'b0;
            slot_fire   <= '0;
            slot_busy   <= '0;
            in_flight   <= '0;
            for (int j = 0; j < NUM_SLOTS; j++) slot_owner[j] <= '0;
            for (int i = 0; i < NUM_TANKS; i++) cooldown[i] <= '0;
        end else begin
            slot_fire   <= '0;
            grant_valid <= 1'b0;

            for (int i = 0; i < NUM_TANKS; i++) begin
                if (bus.startOfFrame && cooldown[i] != 6'd0) cooldown[i] <= cooldown[i] - 6'd1;
            end

            // Retired missiles free their slot and their owner's in-flight bit.
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (bus.slotDone[j] && slot_busy[j]) begin
                    slot_busy[j]              <= 1'b0;
                    in_flight[slot_owner[j]]  <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.startOfFrame) state <= ARB;
                end
                ARB: begin
                    if (win_found && slot_found) begin
                        grant_tank  <= win_tank;
                        grant_slot  <= free_slot;
                        slot_fire   <= NUM_SLOTS'(1) << free_slot;
                        grant_valid <= 1'b1;
                        state       <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    slot_busy[grant_slot]  <= 1'b1;
                    slot_owner[grant_slot] <= grant_tank;
                    in_flight[grant_tank]  <= 1'b1;
                    cooldown[grant_tank]   <= 6'(COOLDOWN_FRAMES);
                    rr_ptr <= (grant_tank == TW'(NUM_TANKS - 1)) ? '0 : grant_tank + TW'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        owner_packed = '0;
        for (int j = 0; j < NUM_SLOTS; j++) owner_packed[j*TW +: TW] = slot_owner[j];
    end

    assign bus.slotFire     = slot_fire;
    assign bus.slotBusy     = slot_busy;
    assign bus.slotOwner    = owner_packed;
    assign bus.tankInFlight = in_flight;
    assign bus.grantValid   = grant_valid;
    assign bus.grantTank    = grant_tank;
    assign bus.grantSlot    = grant_slot;

endmodule

// File: tb/tb_missile_pool_ctrl.sv
// Self-checking bench for missile_pool_ctrl: fixed vector table, directed multi-frame
// sequences and randomized traffic against a frame-level reference model.
module tb_missile_pool_ctrl;

    localparam int NT = 4;
    localparam int NS = 3;
    localparam int CD = 3;
    localparam int TW = 2;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    missile_pool_ctrl_if #(.NUM_TANKS(NT), .NUM_SLOTS(NS)) bus ();

    missile_pool_ctrl #(
        .NUM_TANKS(NT), .NUM_SLOTS(NS), .COOLDOWN_FRAMES(CD)
    ) dut (
        .clk(clk), .resetN(resetN), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending arbitration/issue steps plus pool bookkeeping.
    int m_phase;   // 0 waiting for frame, 1 arbitration due, 2 fire pulse showing
    int m_rr;
    int m_gt, m_gs;
    int m_cd    [NT];
    bit m_infl  [NT];
    bit m_busy  [NS];
    int m_owner [NS];

    int gq_tank[$];
    int gq_slot[$];

    task automatic model_reset();
        m_phase = 0; m_rr = 0; m_gt = 0; m_gs = 0;
        for (int i = 0; i < NT; i++) begin m_cd[i] = 0; m_infl[i] = 0; end
        for (int j = 0; j < NS; j++) begin m_busy[j] = 0; m_owner[j] = 0; end
    endtask

    task automatic model_edge();
        bit sof;
        int win, slot;
        sof = bus.startOfFrame;
        win = -1;
        slot = -1;
        for (int k = 0; k < NT; k++) begin
            int t;
            t = (m_rr + k) % NT;
            if (win < 0 && bus.fireReq[t] && bus.tankAlive[t] && !m_infl[t] && m_cd[t] == 0) win = t;
        end
        for (int j = NS - 1; j >= 0; j--) if (!m_busy[j]) slot = j;
        if (sof) for (int i = 0; i < NT; i++) if (m_cd[i] > 0) m_cd[i]--;
        for (int j = 0; j < NS; j++) begin
            if (bus.slotDone[j] && m_busy[j]) begin
                m_busy[j] = 0;
                m_infl[m_owner[j]] = 0;
            end
        end
        case (m_phase)
            0: if (sof) m_phase = 1;
            1: begin
                if (win >= 0 && slot >= 0) begin
                    m_gt = win; m_gs = slot; m_phase = 2;
                end else m_phase = 0;
            end
            default: begin
                m_busy[m_gs] = 1;
                m_owner[m_gs] = m_gt;
                m_infl[m_gt] = 1;
                m_cd[m_gt] = CD;
                m_rr = (m_gt + 1) % NT;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic compare_model(input string tag);
        logic [31:0] e_fire, e_busy, e_infl, e_owner;
        e_fire = (m_phase == 2) ? (32'd1 << m_gs) : 32'd0;
        e_busy = '0; e_infl = '0; e_owner = '0;
        for (int j = 0; j < NS; j++) begin
            e_busy[j] = m_busy[j];
            e_owner = e_owner | (32'(m_owner[j]) << (j * TW));
        end
        for (int i = 0; i < NT; i++) e_infl[i] = m_infl[i];
        check({tag, ".slotFire"},     32'(bus.slotFire),     e_fire);
        check({tag, ".slotBusy"},     32'(bus.slotBusy),     e_busy);
        check({tag, ".slotOwner"},    32'(bus.slotOwner),    e_owner);
        check({tag, ".tankInFlight"}, 32'(bus.tankInFlight), e_infl);
        check({tag, ".grantValid"},   32'(bus.grantValid),   32'(m_phase == 2));
        if (m_phase == 2) begin
            check({tag, ".grantTank"}, 32'(bus.grantTank), 32'(m_gt));
            check({tag, ".grantSlot"}, 32'(bus.grantSlot), 32'(m_gs));
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the following negedge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model(tag);
        if (bus.grantValid) begin
            gq_tank.push_back(int'(bus.grantTank));
            gq_slot.push_back(int'(bus.grantSlot));
        end
    endtask

    task automatic drive(input bit sof, input logic [NT-1:0] req, input logic [NT-1:0] alive,
                         input logic [NS-1:0] done);
        bus.startOfFrame = sof;
        bus.fireReq      = req;
        bus.tankAlive    = alive;
        bus.slotDone     = done;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".slotFire"},     32'(bus.slotFire),     0);
        check({tag, ".slotBusy"},     32'(bus.slotBusy),     0);
        check({tag, ".slotOwner"},    32'(bus.slotOwner),    0);
        check({tag, ".tankInFlight"}, 32'(bus.tankInFlight), 0);
        check({tag, ".grantValid"},   32'(bus.grantValid),   0);
        check({tag, ".grantTank"},    32'(bus.grantTank),    0);
        check({tag, ".grantSlot"},    32'(bus.grantSlot),    0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        drive(1'b0, '0, '1, '0);
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        gq_tank.delete();
        gq_slot.delete();
    endtask

    // One frame: startOfFrame for one cycle followed by idle cycles.
    task automatic frame(input string tag, input logic [NT-1:0] req, input int gap);
        drive(1'b1, req, '1, '0);
        cycle(tag);
        drive(1'b0, req, '1, '0);
        for (int c = 0; c < gap; c++) cycle(tag);
    endtask

    typedef struct {
        bit             sof;
        logic [NT-1:0]  req;
        logic [NT-1:0]  alive;
        logic [NS-1:0]  done;
        logic [NS-1:0]  e_fire;
        logic [NS-1:0]  e_busy;
        logic [NT-1:0]  e_infl;
        bit             e_gv;
        logic [1:0]     e_gt;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // Single shot, blocked re-fire, retire, cooldown expiry on the 3rd frame,
        // done on a free slot, and a dead tank requesting.
        vecs[0]  = '{1'b1, 4'b0001, 4'b1111, 3'b000, 3'b000, 3'b000, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 4'b0001, 4'b1111, 3'b000, 3'b001, 3'b000, 4'b0000, 1'b1, 2'd0};
        vecs[2]  = '{1'b0, 4'b0001, 4'b1111, 3'b000, 3'b000, 3'b001, 4'b0001, 1'b0, 2'd0};
        vecs[3]  = '{1'b1, 4'b0001, 4'b1111, 3'b000, 3'b000, 3'b001, 4'b0001, 1'b0, 2'd0};
        vecs[4]  = '{1'b0, 4'b0001, 4'b1111, 3'b000, 3'b000, 3'b001, 4'b0001, 1'b0, 2'd0};
        vecs[5]  = '{1'b0, 4'b0001, 4'b1111, 3'b001, 3'b000, 3'b000, 4'b0000, 1'b0, 2'd0};
        vecs[6]  = '{1'b1, 4'b0001, 4'b1111, 3'b000, 3'b000, 3'b000, 4'b0000, 1'b0, 2'd0};
        vecs[7]  = '{1'b0, 4'b0001, 4'b1111, 3'b000, 3'b000, 3'b000, 4'b0000, 1'b0, 2'd0};
        vecs[8]  = '{1'b1, 4'b0001, 4'b1111, 3'b000, 3'b000, 3'b000, 4'b0000, 1'b0, 2'd0};
        vecs[9]  = '{1'b0, 4'b0001, 4'b1111, 3'b000, 3'b001, 3'b000, 4'b0000, 1'b1, 2'd0};
        vecs[10] = '{1'b0, 4'b0001, 4'b1111, 3'b000, 3'b000, 3'b001, 4'b0001, 1'b0, 2'd0};
        vecs[11] = '{1'b0, 4'b0001, 4'b1111, 3'b010, 3'b000, 3'b001, 4'b0001, 1'b0, 2'd0};
        vecs[12] = '{1'b1, 4'b0010, 4'b1101, 3'b000, 3'b000, 3'b001, 4'b0001, 1'b0, 2'd0};
        vecs[13] = '{1'b0, 4'b0010, 4'b1101, 3'b000, 3'b000, 3'b001, 4'b0001, 1'b0, 2'd0};

        drive(1'b0, '0, '1, '0);
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        resetN = 1'b1;

        for (int r = 0; r < 14; r++) begin
            drive(vecs[r].sof, vecs[r].req, vecs[r].alive, vecs[r].done);
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check($sformatf("vec%0d.slotFire", r),     32'(bus.slotFire),     32'(vecs[r].e_fire));
            check($sformatf("vec%0d.slotBusy", r),     32'(bus.slotBusy),     32'(vecs[r].e_busy));
            check($sformatf("vec%0d.tankInFlight", r), 32'(bus.tankInFlight), 32'(vecs[r].e_infl));
            check($sformatf("vec%0d.grantValid", r),   32'(bus.grantValid),   32'(vecs[r].e_gv));
            if (vecs[r].e_gv) check($sformatf("vec%0d.grantTank", r), 32'(bus.grantTank), 32'(vecs[r].e_gt));
        end

        // Round-robin over three tanks, then pool exhaustion and refill.
        do_reset();
        for (int f = 0; f < 4; f++) frame("rr", 4'b0111, 3);
        check("rr.grant_count", 32'(gq_tank.size()), 3);
        for (int g = 0; g < 3 && g < gq_tank.size(); g++) begin
            check($sformatf("rr.tank%0d", g), 32'(gq_tank[g]), 32'(g));
            check($sformatf("rr.slot%0d", g), 32'(gq_slot[g]), 32'(g));
        end
        for (int f = 0; f < 2; f++) frame("full", 4'b1111, 3);
        check("full.no_grant", 32'(gq_tank.size()), 3);
        drive(1'b0, 4'b1111, '1, 3'b010);
        cycle("full.done");
        frame("refill", 4'b1111, 3);
        check("refill.grant_count", 32'(gq_tank.size()), 4);
        if (gq_tank.size() == 4) begin
            check("refill.tank", 32'(gq_tank[3]), 3);
            check("refill.slot", 32'(gq_slot[3]), 1);
        end

        // Reset asserted during the fire pulse.
        do_reset();
        drive(1'b1, 4'b0001, '1, '0);
        cycle("rst.sof");
        drive(1'b0, 4'b0001, '1, '0);
        cycle("rst.arb");
        check("rst.pulse_before", 32'(bus.slotFire), 1);
        resetN = 1'b0;
        model_reset();
        #1;
        check("rst.fire_drop", 32'(bus.slotFire), 0);
        check("rst.gv_drop", 32'(bus.grantValid), 0);
        @(negedge clk);
        check_reset_values("rst.after");
        resetN = 1'b1;
        gq_tank.delete();
        gq_slot.delete();
        frame("rst.regrant", 4'b0001, 3);
        check("rst.regrant_count", 32'(gq_tank.size()), 1);
        if (gq_tank.size() == 1) check("rst.regrant_tank", 32'(gq_tank[0]), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [NT-1:0] alive;
            logic [NS-1:0] done;
            alive = ($urandom_range(0, 7) != 0) ? '1 : NT'($urandom);
            for (int j = 0; j < NS; j++) done[j] = ($urandom_range(0, 5) == 0);
            drive($urandom_range(0, 4) == 0, NT'($urandom), alive, done);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
